// File: rtl/uart_tx_frame_cfg.sv
// UART transmitter with configurable data width, runtime parity and stop bits,
// per-bit oversampling and a one-word holding register for gap-free streaming.
module uart_tx_frame_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_baud_tick,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic [1:0]           i_par_mode,
  input  logic                 i_two_stop,
  output logic                 o_tx_out,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_hold_data;
  logic [1:0]           r_hold_par;
  logic                 r_hold_two;
  logic                 r_hold_full;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_two_stop;
  logic                 r_stop_cnt;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_tx_out;
  logic                 r_tx_done;

  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_frame_end;
  logic                 w_load;
  logic                 w_hold_wr;
  logic [DATA_BITS-1:0] w_ld_data;
  logic [1:0]           w_ld_par;
  logic                 w_ld_two;

  assign w_accept    = i_tx_valid && !r_hold_full;
  assign w_bit_end   = i_baud_tick && (r_state != ST_IDLE) && (r_tick_cnt == TICK_LAST);
  assign w_frame_end = (r_state == ST_STOP) && w_bit_end && (r_stop_cnt == r_two_stop);
  // Shifter reloads from idle, or at frame end from hold (or straight from the
  // input when hold is empty, so a same-edge accept never enters the hold).
  assign w_load      = ((r_state == ST_IDLE) && w_accept) ||
                       (w_frame_end && (r_hold_full || w_accept));
  assign w_hold_wr   = w_accept && (r_state != ST_IDLE) && !w_frame_end;
  assign w_ld_data   = r_hold_full ? r_hold_data : i_tx_data;
  assign w_ld_par    = r_hold_full ? r_hold_par  : i_par_mode;
  assign w_ld_two    = r_hold_full ? r_hold_two  : i_two_stop;

  assign o_tx_ready  = !r_hold_full;
  assign o_tx_out    = r_tx_out;
  assign o_tx_busy   = (r_state != ST_IDLE);
  assign o_tx_done   = r_tx_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_hold_data <= '0;
      r_hold_par  <= '0;
      r_hold_two  <= 1'b0;
      r_hold_full <= 1'b0;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_two_stop  <= 1'b0;
      r_stop_cnt  <= 1'b0;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_tx_out    <= 1'b1;
      r_tx_done   <= 1'b0;
    end else begin
      r_tx_done <= w_frame_end;

      if (w_hold_wr) begin
        r_hold_data <= i_tx_data;
        r_hold_par  <= i_par_mode;
        r_hold_two  <= i_two_stop;
        r_hold_full <= 1'b1;
      end else if (w_frame_end && r_hold_full) begin
        r_hold_full <= 1'b0;
      end

      if (i_baud_tick && (r_state != ST_IDLE))
        r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;

      if (w_load) begin
        r_state    <= ST_START;
        r_tx_out   <= 1'b0;
        r_shift    <= w_ld_data;
        r_par_en   <= (w_ld_par == 2'b01) || (w_ld_par == 2'b10);
        r_par_bit  <= (w_ld_par == 2'b01) ? ~^w_ld_data : ^w_ld_data;
        r_two_stop <= w_ld_two;
        r_tick_cnt <= '0;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
      end else if (w_bit_end) begin
        case (r_state)
          ST_START: begin
            r_state  <= ST_DATA;
            r_tx_out <= r_shift[0];
          end
          ST_DATA: begin
            if (r_bit_cnt == BIT_LAST) begin
              r_state  <= r_par_en ? ST_PARITY : ST_STOP;
              r_tx_out <= r_par_en ? r_par_bit : 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx_out  <= r_shift[1];
            end
          end
          ST_PARITY: begin
            r_state  <= ST_STOP;
            r_tx_out <= 1'b1;
          end
          ST_STOP: begin
            if (r_stop_cnt == r_two_stop) begin
              r_state  <= ST_IDLE;
              r_tx_out <= 1'b1;
            end else begin
              r_stop_cnt <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_frame_cfg.sv
// Scoreboard bench: directed words push hand-written line patterns; monitors
// collect one line sample per counted baud tick and compare on each tx_done.
module tb_uart_tx_frame_cfg;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       v8 = 1'b0, v5 = 1'b0;
  logic [7:0] d8 = '0;
  logic [4:0] d5 = '0;
  logic [1:0] pm8 = '0, pm5 = '0;
  logic       ts8 = 1'b0, ts5 = 1'b0;
  logic       rdy8, out8, busy8, done8;
  logic       rdy5, out5, busy5, done5;

  int    n_chk = 0, n_pass = 0;
  string q8[$];
  string q5[$];
  string acc8 = "", acc5 = "";

  uart_tx_frame_cfg #(.DATA_BITS(8), .OVERSAMPLE(1)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_tx_valid(v8), .o_tx_ready(rdy8),
    .i_tx_data(d8), .i_par_mode(pm8), .i_two_stop(ts8), .o_tx_out(out8),
    .o_tx_busy(busy8), .o_tx_done(done8));

  uart_tx_frame_cfg #(.DATA_BITS(5), .OVERSAMPLE(16)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_tx_valid(v5), .o_tx_ready(rdy5),
    .i_tx_data(d5), .i_par_mode(pm5), .i_two_stop(ts5), .o_tx_out(out5),
    .o_tx_busy(busy5), .o_tx_done(done5));

  always #5 clk = ~clk;

  // Baud tick every third clock, updated just after the rising edge.
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk); #1;
      tick = (tc == 0);
      tc = (tc + 1) % 3;
    end
  end

  task automatic chk(input string name, input bit ok, input string act, input string req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, want %s", name, act, req);
  endtask

  task automatic chkb(input string name, input logic a, input logic r);
    chk(name, a === r, $sformatf("%b", a), $sformatf("%b", r));
  endtask

  function automatic string expand(input string s, input int os);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++)
      for (int j = 0; j < os; j++) r = {r, s.substr(i, i)};
    return r;
  endfunction

  // Monitors: one sample per counted tick while busy; done closes the frame.
  always @(negedge clk) begin
    string e;
    if (rst) acc8 = "";
    else begin
      if (done8) begin
        if (q8.size() == 0) chk("done8_unexpected", 1'b0, "pulse", "none");
        else begin
          e = expand(q8.pop_front(), 1);
          chk("frame8", acc8 == e, acc8, e);
        end
        acc8 = "";
      end
      if (tick && busy8) begin
        if (out8) acc8 = {acc8, "1"}; else acc8 = {acc8, "0"};
      end
    end
  end

  always @(negedge clk) begin
    string e;
    if (rst) acc5 = "";
    else begin
      if (done5) begin
        if (q5.size() == 0) chk("done5_unexpected", 1'b0, "pulse", "none");
        else begin
          e = expand(q5.pop_front(), 16);
          chk("frame5", acc5 == e, acc5, e);
        end
        acc5 = "";
      end
      if (tick && busy5) begin
        if (out5) acc5 = {acc5, "1"}; else acc5 = {acc5, "0"};
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send(input int w, input logic [8:0] d, input logic [1:0] pm,
                      input logic ts, input string e, input bit align);
    int n;
    n = 0;
    while (((w == 0) ? !rdy8 : !rdy5) && n < 1000) begin step(); n++; end
    if (n >= 1000) chk("ready_timeout", 1'b0, "low", "high");
    if (align) while (!tick) step();
    if (w == 0) begin v8 = 1'b1; d8 = d[7:0]; pm8 = pm; ts8 = ts; q8.push_back(e); end
    else        begin v5 = 1'b1; d5 = d[4:0]; pm5 = pm; ts5 = ts; q5.push_back(e); end
    step();
    // Scramble inputs after accept; the frame in flight must not change.
    v8 = 1'b0; v5 = 1'b0;
    d8 = ~d8; d5 = ~d5; pm8 = ~pm8; pm5 = ~pm5; ts8 = ~ts8; ts5 = ~ts5;
  endtask

  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while (((w == 0) ? (q8.size() != 0 || busy8) : (q5.size() != 0 || busy5)) && n < 3000) begin
      step(); n++;
    end
    if (n >= 3000) chk($sformatf("idle_timeout%0d", w), 1'b0, "busy", "idle");
  endtask

  initial begin
    int n;
    repeat (3) step();
    chkb("rst_ready8", rdy8, 1'b1);
    chkb("rst_out8", out8, 1'b1);
    chkb("rst_busy8", busy8, 1'b0);
    chkb("rst_done8", done8, 1'b0);
    chkb("rst_out5", out5, 1'b1);
    chkb("rst_ready5", rdy5, 1'b1);
    rst = 1'b0;
    step();

    send(0, 9'h55, 2'b00, 1'b0, "0101010101", 1'b0);   wait_idle(0);
    send(0, 9'h07, 2'b01, 1'b0, "01110000001", 1'b0);  wait_idle(0);
    send(0, 9'h07, 2'b10, 1'b0, "01110000011", 1'b0);  wait_idle(0);
    send(0, 9'h00, 2'b10, 1'b1, "000000000011", 1'b1); wait_idle(0);

    // Back-to-back: second word sits in hold, then streams with no gap.
    send(0, 9'hA5, 2'b00, 1'b0, "0101001011", 1'b0);
    send(0, 9'h3C, 2'b00, 1'b0, "0001111001", 1'b0);
    chkb("b2b_ready_low", rdy8, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!done8 && n < 500);
    chkb("b2b_done_seen", done8, 1'b1);
    chkb("b2b_busy", busy8, 1'b1);
    chkb("b2b_start", out8, 1'b0);
    chkb("b2b_ready_up", rdy8, 1'b1);
    wait_idle(0);

    send(1, 9'h1F, 2'b00, 1'b0, "0111111", 1'b1);
    wait_idle(1);

    // Reset during data bit 3 with hold full.
    send(0, 9'hF0, 2'b00, 1'b0, "", 1'b0);
    send(0, 9'h11, 2'b00, 1'b0, "", 1'b0);
    chkb("mid_ready_low", rdy8, 1'b0);
    n = 0;
    while (acc8.len() < 4 && n < 500) begin @(negedge clk); #1; n++; end
    step();
    chkb("pre_rst_d3", out8, 1'b0);
    rst = 1'b1;
    #1;
    chkb("mid_rst_out", out8, 1'b1);
    chkb("mid_rst_busy", busy8, 1'b0);
    chkb("mid_rst_ready", rdy8, 1'b1);
    chkb("mid_rst_done", done8, 1'b0);
    q8.delete();
    step(); step();
    rst = 1'b0;
    repeat (20) step();
    chkb("post_rst_busy", busy8, 1'b0);
    send(0, 9'hC3, 2'b00, 1'b0, "0110000111", 1'b0);
    wait_idle(0);

    chk("q8_drained", q8.size() == 0, $sformatf("%0d", q8.size()), "0");
    chk("q5_drained", q5.size() == 0, $sformatf("%0d", q5.size()), "0");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
